// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result valid-ready bundle shared by cla_pipe_adder and its upstream/downstream
interface cla_pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dina;
   logic [WIDTH-1:0] dinb;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, dina, dinb, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, dina, dinb, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined add/sub, one carry-lookahead segment per stage, registered result with valid/ready flow control
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 16
) (
   input logic            clk,
   input logic            rst_n,
   cla_pipe_adder_if.slave p
);
   localparam int NSEG = WIDTH / SEG_W;
   localparam int NG   = SEG_W / 4;

   function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] pr, input logic c);
      return {g[2] | pr[2] & g[1] | pr[2] & pr[1] & g[0] | pr[2] & pr[1] & pr[0] & c,
              g[1] | pr[1] & g[0] | pr[1] & pr[0] & c,
              g[0] | pr[0] & c,
              c};
   endfunction

   // group carries are flattened sums of products, so no carry ripples between groups
   function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b, input logic ci);
      logic [SEG_W-1:0] g, pr, s;
      logic [NG-1:0]    gg, pg;
      logic [NG:0]      cg;
      logic             t, m;
      g  = a & b;
      pr = a ^ b;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3] | pr[4*j+3] & g[4*j+2] | pr[4*j+3] & pr[4*j+2] & g[4*j+1] | (&pr[4*j+1 +: 3]) & g[4*j];
         pg[j] = &pr[4*j +: 4];
      end
      for (int j = 0; j <= NG; j++) begin
         t = ci;
         for (int k = 0; k < j; k++) t = t & pg[k];
         for (int i = 0; i < j; i++) begin
            m = gg[i];
            for (int k = i + 1; k < j; k++) m = m & pg[k];
            t = t | m;
         end
         cg[j] = t;
      end
      for (int j = 0; j < NG; j++) s[4*j +: 4] = pr[4*j +: 4] ^ cla4(g[4*j +: 4], pr[4*j +: 4], cg[j]);
      return {cg[NG], s};
   endfunction

   logic             adv;
   logic [WIDTH-1:0] a_in [NSEG];
   logic [WIDTH-1:0] b_in [NSEG];
   logic [WIDTH-1:0] s_in [NSEG];
   logic [NSEG-1:0]  c_in, v_in;
   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] a_d [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic [WIDTH-1:0] b_d [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic [WIDTH-1:0] s_d [NSEG];
   logic [NSEG-1:0]  c_q, c_d, v_q, v_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             out_valid_q, out_valid_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   assign adv         = ~out_valid_q | p.out_ready;
   assign p.in_ready  = adv;
   assign p.out_valid = out_valid_q;
   assign p.sum       = sum_q;
   assign p.cout      = cout_q;
   assign p.ovf       = ovf_q;
   assign p.zero      = zero_q;

   // stage 0 sees the live mode-adjusted operands, later stages see their predecessor's registers
   always_comb begin
      a_in[0] = p.dina;
      b_in[0] = p.sub ? ~p.dinb : p.dinb;
      s_in[0] = '0;
      c_in[0] = p.sub | p.cin;
      v_in[0] = p.in_valid;
      for (int k = 1; k < NSEG; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         s_in[k] = s_q[k-1];
         c_in[k] = c_q[k-1];
         v_in[k] = v_q[k-1];
      end
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      c_d         = c_q;
      v_d         = v_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      if (adv) begin
         for (int k = 0; k < NSEG; k++) begin
            a_d[k] = a_in[k];
            b_d[k] = b_in[k];
            s_d[k] = s_in[k];
            v_d[k] = v_in[k];
            {c_d[k], s_d[k][k*SEG_W +: SEG_W]} = seg_add(a_in[k][k*SEG_W +: SEG_W], b_in[k][k*SEG_W +: SEG_W], c_in[k]);
         end
         out_valid_d = v_q[NSEG-1];
         if (v_q[NSEG-1]) begin
            sum_d  = s_q[NSEG-1];
            cout_d = c_q[NSEG-1];
            ovf_d  = (a_q[NSEG-1][WIDTH-1] == b_q[NSEG-1][WIDTH-1]) & (s_q[NSEG-1][WIDTH-1] != a_q[NSEG-1][WIDTH-1]);
            zero_d = s_q[NSEG-1] == '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q         <= '0;
         v_q         <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         c_q         <= c_d;
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: vector table, backpressure/reset sequences and random streaming checked against an arithmetic model
module tb_cla_pipe_adder;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   int           checks = 0;
   int           errors = 0;
   res_t         exp_q[$];
   logic [W-1:0] got[$];
   res_t         m_e;
   vec_t         vt[$];

   cla_pipe_adder_if #(.WIDTH(W)) p ();
   cla_pipe_adder #(.WIDTH(W), .SEG_W(16)) dut (.clk(clk), .rst_n(rst_n), .p(p));

   always #5 clk = ~clk;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      res_t   r;
      longint ideal;
      r.sum  = s ? a - b : a + b + W'(c);
      r.cout = s ? a >= b : ({1'b0, a} + {1'b0, b} + 33'(c)) > 33'h0_FFFF_FFFF;
      ideal  = s ? longint'($signed(a)) - longint'($signed(b))
                 : longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      r.ovf  = ideal > 64'sh7FFF_FFFF || ideal < -64'sh8000_0000;
      r.zero = r.sum == '0;
      return r;
   endfunction

   function automatic logic [W-1:0] rnd();
      int sel;
      sel = $urandom_range(0, 7);
      return sel == 0 ? 32'hFFFF_FFFF : sel == 1 ? 32'h0000_FFFF : sel == 2 ? 32'h8000_0000 : $urandom;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      int n;
      n = 0;
      p.in_valid = 1'b1;
      p.dina     = a;
      p.dinb     = b;
      p.cin      = c;
      p.sub      = s;
      while (!p.in_ready && n < 50) begin
         step();
         n++;
      end
      chk("send_ready", p.in_ready, 1);
      step();
      p.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!p.out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   // scoreboard: every accepted operand set must come out once, in order, equal to the model
   always @(negedge clk) begin
      if (!rst_n) exp_q.delete();
      else begin
         if (p.out_valid && p.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra: got sum %0h with nothing expected", p.sum);
            end else begin
               m_e = exp_q.pop_front();
               if ({p.sum, p.cout, p.ovf, p.zero} !== m_e) begin
                  errors++;
                  $display("FAIL sb_result: got sum %0h c%0b v%0b z%0b expected sum %0h c%0b v%0b z%0b",
                           p.sum, p.cout, p.ovf, p.zero, m_e.sum, m_e.cout, m_e.ovf, m_e.zero);
               end
               got.push_back(p.sum);
            end
         end
         if (p.in_valid && p.in_ready) exp_q.push_back(model(p.dina, p.dinb, p.cin, p.sub));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int n;
      p.in_valid  = 1'b0;
      p.out_ready = 1'b1;
      p.dina      = '0;
      p.dinb      = '0;
      p.cin       = 1'b0;
      p.sub       = 1'b0;
      vt.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
      vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vt.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
      vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
      vt.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0});
      vt.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0});
      vt.push_back('{32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vt.push_back('{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vt.push_back('{32'hFFFF_FFF0, 32'h0000_000F, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", p.out_valid, 0);
      chk("rst_in_ready", p.in_ready, 1);
      chk("rst_outputs", {p.sum, p.cout, p.ovf, p.zero}, 0);
      repeat (2) step();
      rst_n = 1'b1;

      foreach (vt[i]) begin
         send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
         wait_out(lat);
         chk($sformatf("vec%0d_lat", i), lat, 2);
         chk($sformatf("vec%0d_res", i), {p.sum, p.cout, p.ovf, p.zero}, {vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero});
         step();
      end

      // three ops into a stalled output: ready must drop, order must survive
      step();
      got.delete();
      p.out_ready = 1'b0;
      send(1, 1, 1'b0, 1'b0);
      send(2, 2, 1'b0, 1'b0);
      send(3, 3, 1'b0, 1'b0);
      chk("bp_in_ready_low", p.in_ready, 0);
      chk("bp_out_valid", p.out_valid, 1);
      repeat (2) step();
      chk("bp_hold_sum", p.sum, 2);
      chk("bp_hold_ready", p.in_ready, 0);
      p.out_ready = 1'b1;
      n = 0;
      while (got.size() < 3 && n < 20) begin
         step();
         n++;
      end
      chk("bp_count", got.size(), 3);
      if (got.size() == 3) for (int i = 0; i < 3; i++) chk($sformatf("bp_order%0d", i), got[i], 2 * (i + 1));
      repeat (3) step();
      chk("bp_no_dup", got.size(), 3);
      chk("bp_idle", p.out_valid, 0);

      for (int i = 0; i < 100; i++) begin
         p.in_valid = 1'b1;
         p.dina     = rnd();
         p.dinb     = rnd();
         p.cin      = 1'($urandom_range(0, 1));
         p.sub      = 1'($urandom_range(0, 1));
         step();
         if (i >= 2) chk($sformatf("stream_valid%0d", i), p.out_valid, 1);
      end
      p.in_valid = 1'b0;
      repeat (4) step();
      chk("stream_drain", exp_q.size(), 0);

      for (int i = 0; i < 300; i++) begin
         p.in_valid  = 1'($urandom_range(0, 1));
         p.out_ready = $urandom_range(0, 3) != 0;
         p.dina      = rnd();
         p.dinb      = rnd();
         p.cin       = 1'($urandom_range(0, 1));
         p.sub       = 1'($urandom_range(0, 1));
         step();
      end
      p.in_valid  = 1'b0;
      p.out_ready = 1'b1;
      repeat (5) step();
      chk("rand_drain", exp_q.size(), 0);

      send(32'd100, 32'd200, 1'b0, 1'b0);
      send(32'd300, 32'd400, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", p.out_valid, 0);
      chk("mid_rst_ready", p.in_ready, 1);
      chk("mid_rst_outputs", {p.sum, p.cout, p.ovf, p.zero}, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("mid_rst_stale%0d", i), p.out_valid, 0);
         step();
      end
      send(32'd9, 32'd1, 1'b0, 1'b0);
      wait_out(lat);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_sum", p.sum, 10);
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
